egress_arbiter: RTL and testbench

Four-to-one egress arbiter that drains the four output FIFOs of the PCIE switch (lanes 4–7) into a single 12-bit stream.

- Pops at most one FIFO per cycle and honours downstream back-pressure.
- Tags each word with its source lane.
- Keeps a per-lane pop counter, readable through the same `req`/`idx` interface the switch exposes.
- Sits at the output end of the switch, in place of the bench-driven `pop` vector.

---
 rtl/egress_arbiter_if.sv | 46 ++++
 rtl/egress_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_egress_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/egress_arbiter_if.sv
// egress_arbiter_if
// Bundles every non-clock, non-reset signal of the egress arbiter.
//
// Signal groups:
//   FIFO side     : empty, data_out4..data_out7 (read data, valid the cycle
//                   after its pop), pop (one-hot or zero strobes)
//   Egress stream : data_out, lane_out, valid_out, almost_full_in
//   Counter read  : req, idx, cnt_out, cnt_valid
//   Control       : init (hold in INIT), idle (IDLE state indicator)
//
// Modports:
//   master - the arbiter itself (drives pops, egress stream, counter data)
//   slave  - the surrounding switch / downstream logic
interface egress_arbiter_if #(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
) ();
  logic                    init;
  logic [3:0]              empty;
  logic [TAMANO_DATOS-1:0] data_out4;
  logic [TAMANO_DATOS-1:0] data_out5;
  logic [TAMANO_DATOS-1:0] data_out6;
  logic [TAMANO_DATOS-1:0] data_out7;
  logic                    almost_full_in;
  logic                    req;
  logic [2:0]              idx;
  logic [3:0]              pop;
  logic [TAMANO_DATOS-1:0] data_out;
  logic [1:0]              lane_out;
  logic                    valid_out;
  logic [CNT_W-1:0]        cnt_out;
  logic                    cnt_valid;
  logic                    idle;

  modport master (
    input  init, empty, data_out4, data_out5, data_out6, data_out7,
           almost_full_in, req, idx,
    output pop, data_out, lane_out, valid_out, cnt_out, cnt_valid, idle
  );

  modport slave (
    output init, empty, data_out4, data_out5, data_out6, data_out7,
           almost_full_in, req, idx,
    input  pop, data_out, lane_out, valid_out, cnt_out, cnt_valid, idle
  );
endinterface

// File: rtl/egress_arbiter.sv
// egress_arbiter
// Four-to-one egress arbiter: drains output FIFOs 4..7 of the switch into a
// single TAMANO_DATOS-bit stream, tagging each word with its source lane and
// counting pops per lane. At most one FIFO is popped per cycle and new pops
// stall while the downstream reports almost-full.
//
// Ports:
//   clk   - single clock, all logic on posedge
//   reset - synchronous, active-high; clears all state, drops in-flight words
//   bus   - egress_arbiter_if.master (FIFO status/data/pops, egress stream,
//           counter read port, init/idle)
//
// Build option:
//   EGRESS_STRICT_PRIORITY_EN - defined: fixed priority, lane 0 highest,
//   lane 3 lowest. Undefined (default): round-robin, search starting one past
//   the last granted lane.
module egress_arbiter #(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  egress_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      idle_q;
  logic [1:0]                ptr_q, ptr_d;
  logic [2:0]                pick_s;     // {found, lane}
  logic [3:0]                pop_s;
  logic                      s1_valid_q;
  logic [1:0]                s1_lane_q;
  logic [TAMANO_DATOS-1:0]   data_sel_s;
  logic [TAMANO_DATOS-1:0]   data_out_q;
  logic [1:0]                lane_out_q;
  logic                      valid_out_q;
  logic [3:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]          cnt_rd_s;
  logic [CNT_W-1:0]          cnt_out_q;
  logic                      cnt_valid_q;

`ifdef EGRESS_STRICT_PRIORITY_EN
  // Fixed priority: scan from lowest priority upward so the best hit lands last.
  function automatic logic [2:0] pick_lane(input logic [3:0] ne);
    logic [2:0] res;
    logic [1:0] lane;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      lane = 2'(i);
      res  = ne[lane] ? {1'b1, lane} : res;
    end
    return res;
  endfunction
`else
  // Round-robin: lanes last+1 .. last+4 (mod 4) in priority order; scanning
  // backwards leaves the first non-empty lane after 'last' as the result.
  function automatic logic [2:0] pick_lane(input logic [3:0] ne, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] lane;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      lane = last + 2'(i);
      res  = ne[lane] ? {1'b1, lane} : res;
    end
    return res;
  endfunction
`endif

  // Grant winner among the non-empty lanes
  always_comb begin
    pick_s = 3'b000;
`ifdef EGRESS_STRICT_PRIORITY_EN
    pick_s = pick_lane(~bus.empty);
`else
    pick_s = pick_lane(~bus.empty, ptr_q);
`endif
  end

  // Pop strobes; init and reset suppress pops in the very cycle they rise
  always_comb begin
    pop_s = 4'b0000;
    if ((state_q == ST_ACTIVE) && !reset && !bus.init && !bus.almost_full_in && pick_s[2]) begin
      pop_s = 4'b0001 << pick_s[1:0];
    end else begin
      pop_s = 4'b0000;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        if (bus.init) state_d = ST_INIT;
        else          state_d = ST_IDLE;
      end
      ST_INIT: begin
        if (bus.init) state_d = ST_INIT;
        else          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.init)                 state_d = ST_INIT;
        else if (bus.empty != 4'hF)   state_d = ST_ACTIVE;
        else                          state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        // The egress pipeline drains regardless of state, so once every FIFO
        // is empty nothing new can be popped and returning to IDLE is safe.
        if (bus.init)                 state_d = ST_INIT;
        else if (bus.empty == 4'hF)   state_d = ST_IDLE;
        else                          state_d = ST_ACTIVE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Pointer remembers the last lane actually popped
  always_comb begin
    ptr_d = ptr_q;
    if (pop_s != 4'b0000) ptr_d = pick_s[1:0];
    else                  ptr_d = ptr_q;
  end

  // Per-lane pop counters; cleared by init and held at zero in INIT
  always_comb begin
    cnt_d = cnt_q;
    if (bus.init || (state_q == ST_INIT)) begin
      cnt_d = {4{{CNT_W{1'b0}}}};
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_d[k] = pop_s[k] ? (cnt_q[k] + CNT_W'(1)) : cnt_q[k];
      end
    end
  end

  // Counter read mux: indices 4..7 have no counter and read as zero
  always_comb begin
    cnt_rd_s = {CNT_W{1'b0}};
    if (bus.idx[2]) cnt_rd_s = {CNT_W{1'b0}};
    else            cnt_rd_s = cnt_q[bus.idx[1:0]];
  end

  // Read-data mux for the word popped in the previous cycle
  always_comb begin
    data_sel_s = {TAMANO_DATOS{1'b0}};
    case (s1_lane_q)
      2'd0:    data_sel_s = bus.data_out4;
      2'd1:    data_sel_s = bus.data_out5;
      2'd2:    data_sel_s = bus.data_out6;
      2'd3:    data_sel_s = bus.data_out7;
      default: data_sel_s = {TAMANO_DATOS{1'b0}};
    endcase
  end

  // State, pointer, idle flag and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      idle_q  <= 1'b0;
      ptr_q   <= 2'd3;
      cnt_q   <= {4{{CNT_W{1'b0}}}};
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == ST_IDLE);
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Egress pipeline: lane tag at pop, data one cycle later, valid after that.
  // init does not touch it, so words already popped still emerge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_lane_q   <= 2'd0;
      data_out_q  <= {TAMANO_DATOS{1'b0}};
      lane_out_q  <= 2'd0;
      valid_out_q <= 1'b0;
    end else begin
      s1_valid_q  <= (pop_s != 4'b0000);
      s1_lane_q   <= (pop_s != 4'b0000) ? pick_s[1:0] : s1_lane_q;
      data_out_q  <= s1_valid_q ? data_sel_s : data_out_q;
      lane_out_q  <= s1_valid_q ? s1_lane_q : lane_out_q;
      valid_out_q <= s1_valid_q;
    end
  end

  // Counter read port: value sampled before this cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_out_q   <= {CNT_W{1'b0}};
      cnt_valid_q <= 1'b0;
    end else begin
      cnt_out_q   <= bus.req ? cnt_rd_s : cnt_out_q;
      cnt_valid_q <= bus.req;
    end
  end

  assign bus.pop       = pop_s;
  assign bus.data_out  = data_out_q;
  assign bus.lane_out  = lane_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.cnt_out   = cnt_out_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_egress_arbiter.sv
`timescale 1ns/1ps
// tb_egress_arbiter: bench for egress_arbiter. The FIFOs are modelled as
// queues; expected egress words and counter replies are queued with the time
// they are due and compared by an independent monitor.
module tb_egress_arbiter;
  localparam int DW = 12;
  localparam int CW = 5;

  typedef struct {
    logic [1:0]    lane;
    logic [DW-1:0] data;
    time           due;
  } word_t;

  typedef struct {
    logic [CW-1:0] cnt;
    time           due;
  } cnt_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  egress_arbiter_if #(.TAMANO_DATOS(DW), .CNT_W(CW)) bus ();
  egress_arbiter #(.TAMANO_DATOS(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fifo_q [4][$];
  word_t         sb_q [$];
  cnt_t          cnt_sb_q [$];

  // reference model state
  bit            m_hold;     // in RESET or INIT
  bit            m_active;   // in ACTIVE
  int            m_last;     // last granted lane
  int            m_cnt [4];
  logic [DW-1:0] rd_word [4];
  logic [3:0]    rd_vld;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] ne, input int last);
`ifdef EGRESS_STRICT_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (ne[i]) return i;
    if (last > 3) return -1;
`else
    for (int i = 1; i <= 4; i++) if (ne[(last + i) % 4]) return (last + i) % 4;
`endif
    return -1;
  endfunction

  task automatic set_data(input int k, input logic [DW-1:0] v);
    case (k)
      0: bus.data_out4 = v;
      1: bus.data_out5 = v;
      2: bus.data_out6 = v;
      default: bus.data_out7 = v;
    endcase
  endtask

  // One clock cycle: inputs are already applied (just after posedge)
  task automatic cycle();
    logic [3:0] ne;
    logic [3:0] exp_pop;
    int         g;
    bit         act_next;
    word_t      w;
    cnt_t       c;
    for (int k = 0; k < 4; k++) ne[k] = (fifo_q[k].size() != 0);
    bus.empty = ~ne;
    @(negedge clk);
    g = pick(ne, m_last);
    exp_pop = 4'b0000;
    if (m_active && !reset && !bus.init && !bus.almost_full_in && g >= 0) exp_pop[g] = 1'b1;
    check("pop", 32'(bus.pop), 32'(exp_pop));
    check("idle", 32'(bus.idle), 32'(!m_hold && !m_active));
    if (exp_pop != 4'b0000) begin
      w.lane = 2'(g);
      w.data = fifo_q[g][0];
      w.due  = $time + 20;
      sb_q.push_back(w);
    end
    @(posedge clk);
    if (bus.req && !reset) begin
      c.cnt = (bus.idx < 3'd4) ? CW'(m_cnt[bus.idx[1:0]]) : {CW{1'b0}};
      c.due = $time + 5;
      cnt_sb_q.push_back(c);
    end
    rd_vld = 4'b0000;
    if (exp_pop != 4'b0000) begin
      rd_word[g] = fifo_q[g].pop_front();
      rd_vld[g]  = 1'b1;
      m_last     = g;
      m_cnt[g]   = (m_cnt[g] + 1) % (1 << CW);
    end
    act_next = !m_hold && !bus.init && (ne != 4'b0000);
    m_hold   = bus.init;
    m_active = act_next;
    if (bus.init) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    if (reset) begin
      m_hold = 1'b1;
      m_active = 1'b0;
      m_last = 3;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      sb_q.delete();
      cnt_sb_q.delete();
    end
    #1;
    for (int k = 0; k < 4; k++) set_data(k, rd_vld[k] ? rd_word[k] : DW'($urandom));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Output monitor
  initial begin
    word_t w;
    cnt_t  c;
    bit    exp_v;
    bit    exp_c;
    forever begin
      @(negedge clk);
      exp_v = (sb_q.size() != 0) && (sb_q[0].due == $time);
      check("valid_out", 32'(bus.valid_out), 32'(exp_v));
      if (exp_v) begin
        w = sb_q.pop_front();
        if (bus.valid_out === 1'b1) begin
          check("lane_out", 32'(bus.lane_out), 32'(w.lane));
          check("data_out", 32'(bus.data_out), 32'(w.data));
        end
      end
      exp_c = (cnt_sb_q.size() != 0) && (cnt_sb_q[0].due == $time);
      check("cnt_valid", 32'(bus.cnt_valid), 32'(exp_c));
      if (exp_c) begin
        c = cnt_sb_q.pop_front();
        if (bus.cnt_valid === 1'b1) check("cnt_out", 32'(bus.cnt_out), 32'(c.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.init = 1'b0;
    bus.empty = 4'hF;
    bus.almost_full_in = 1'b0;
    bus.req = 1'b0;
    bus.idx = 3'd0;
    for (int k = 0; k < 4; k++) set_data(k, {DW{1'b0}});
    m_hold = 1'b1;
    m_active = 1'b0;
    m_last = 3;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    rd_vld = 4'b0000;

    // reset held for two edges
    @(posedge clk);
    @(negedge clk);
    check("rst_pop", 32'(bus.pop), 32'h0);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_lane_out", 32'(bus.lane_out), 32'h0);
    check("rst_valid_out", 32'(bus.valid_out), 32'h0);
    check("rst_cnt_out", 32'(bus.cnt_out), 32'h0);
    check("rst_cnt_valid", 32'(bus.cnt_valid), 32'h0);
    check("rst_idle", 32'(bus.idle), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(1);
    #3;
    check("idle_after_reset", 32'(bus.idle), 32'h1);

    // round-robin over all four lanes
    fifo_q[0].push_back(12'h1FB); fifo_q[0].push_back(12'h0A1);
    fifo_q[1].push_back(12'h2F6); fifo_q[1].push_back(12'h111);
    fifo_q[2].push_back(12'h3BB); fifo_q[2].push_back(12'h222);
    fifo_q[3].push_back(12'h3D7); fifo_q[3].push_back(12'h333);
    run(14);

    // back-pressure mid-stream
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 6; j++) fifo_q[k].push_back(DW'($urandom));
    run(3);
    bus.almost_full_in = 1'b1;
    run(5);
    bus.almost_full_in = 1'b0;
    run(30);

    // single lane
    for (int j = 0; j < 3; j++) fifo_q[1].push_back(DW'($urandom));
    run(8);

    // counter wrap and read
    bus.init = 1'b1;
    run(2);
    bus.init = 1'b0;
    run(1);
    for (int j = 0; j < 33; j++) fifo_q[2].push_back(DW'($urandom));
    run(40);
    bus.req = 1'b1;
    bus.idx = 3'd2;
    run(1);
    bus.idx = 3'd5;
    run(1);
    bus.idx = 3'd0;
    run(1);
    bus.req = 1'b0;
    run(2);

    // randomized traffic with back-pressure, reads, init and reset pulses
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 4; k++)
        if (fifo_q[k].size() < 6 && $urandom_range(0, 99) < 30) fifo_q[k].push_back(DW'($urandom));
      bus.almost_full_in = ($urandom_range(0, 9) == 0);
      bus.req  = ($urandom_range(0, 3) == 0);
      bus.idx  = 3'($urandom_range(0, 7));
      bus.init = ($urandom_range(0, 199) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      cycle();
    end

    // drain and final counter reads
    bus.almost_full_in = 1'b0;
    bus.req = 1'b0;
    bus.init = 1'b0;
    reset = 1'b0;
    run(40);
    for (int k = 0; k < 4; k++) begin
      bus.req = 1'b1;
      bus.idx = 3'(k);
      run(1);
    end
    bus.req = 1'b0;
    run(4);
    check("words_outstanding", 32'(sb_q.size()), 32'h0);
    check("cnt_outstanding", 32'(cnt_sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
